// File: rtl/micro_seq_if.sv
// Bus bundle between the micro-sequencer and its host.
// Host side (master): microword load port, run control (start, halt, loop_addr, loop_count).
// Sequencer side (slave): registered datapath controls (initial_r, reg_write, reg_read1,
// reg_read2, alu_op, buff_ctrl, reg_write_en) and status (busy, done, pc).
interface micro_seq_if;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [41:0] load_data;
  logic        start;
  logic [3:0]  loop_addr;
  logic [7:0]  loop_count;
  logic        halt;

  logic [15:0] initial_r;
  logic [3:0]  reg_write;
  logic [3:0]  reg_read1;
  logic [3:0]  reg_read2;
  logic [7:0]  alu_op;
  logic [3:0]  buff_ctrl;
  logic        reg_write_en;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  modport master (
    output load_en, load_addr, load_data, start, loop_addr, loop_count, halt,
    input  initial_r, reg_write, reg_read1, reg_read2, alu_op, buff_ctrl, reg_write_en,
    input  busy, done, pc
  );

  modport slave (
    input  load_en, load_addr, load_data, start, loop_addr, loop_count, halt,
    output initial_r, reg_write, reg_read1, reg_read2, alu_op, buff_ctrl, reg_write_en,
    output busy, done, pc
  );
endinterface

// File: rtl/micro_seq.sv
// Looping microcode sequencer with a 16 x 42-bit microword store.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset; also clears the microword store
//   bus    - micro_seq_if.slave: load port, run control, registered datapath controls,
//            busy / done / pc status
// Word layout: {imm[41:26], wsel[25:22], r1[21:18], r2[17:14], op[13:6], buf[5:2], we[1],
// last[0]}. The first pass starts at address 0, later passes at the captured loop_addr.
module micro_seq #(
  parameter logic [7:0] NOP_OP = 8'h00
) (
  input logic        clk,
  input logic        reset,
  micro_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Datapath fields of a word (everything except the last bit) with NOP values.
  localparam logic [40:0] NopWord = {28'h0, NOP_OP, 5'h0};

  state_e      state_q;
  logic [41:0] mem_q [16];
  logic [3:0]  pc_q;
  logic [3:0]  loop_q;
  logic [7:0]  rem_q;
  logic        fin_q;   // final word already issued; next edge goes to DONE
  logic [40:0] dp_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  issue_addr;
  logic [41:0] word;
  logic        word_last;
  logic [3:0]  cur_loop;
  logic [7:0]  cur_rem;
  logic [3:0]  next_pc;
  logic [7:0]  next_rem;
  logic        next_fin;

  // Issue bookkeeping shared by the start edge (address 0, live loop inputs) and RUN
  // (address pc, captured loop settings). rem of 0 means unbounded and is never stepped.
  always_comb begin
    issue_addr = (state_q == StRun) ? pc_q : 4'd0;
    word       = mem_q[issue_addr];
    word_last  = word[0] || (issue_addr == 4'd15);
    cur_loop   = (state_q == StRun) ? loop_q : bus.loop_addr;
    cur_rem    = (state_q == StRun) ? rem_q : bus.loop_count;
    next_pc    = issue_addr + 4'd1;
    next_rem   = cur_rem;
    next_fin   = 1'b0;
    if (word_last) begin
      next_pc = cur_loop;
      if (cur_rem == 8'd1) begin
        next_fin = 1'b1;
      end else if (cur_rem != 8'd0) begin
        next_rem = cur_rem - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
      pc_q   <= 4'd0;
      loop_q <= 4'd0;
      rem_q  <= 8'd0;
      fin_q  <= 1'b0;
      dp_q   <= NopWord;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
          end else if (bus.start) begin
            state_q <= StRun;
            dp_q    <= word[41:1];
            pc_q    <= next_pc;
            loop_q  <= bus.loop_addr;
            rem_q   <= next_rem;
            fin_q   <= next_fin;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (bus.halt || fin_q) begin
            state_q <= StDone;
            dp_q    <= NopWord;
            pc_q    <= 4'd0;
            rem_q   <= 8'd0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            dp_q  <= word[41:1];
            pc_q  <= next_pc;
            rem_q <= next_rem;
            fin_q <= next_fin;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          dp_q    <= NopWord;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.initial_r    = dp_q[40:25];
  assign bus.reg_write    = dp_q[24:21];
  assign bus.reg_read1    = dp_q[20:17];
  assign bus.reg_read2    = dp_q[16:13];
  assign bus.alu_op       = dp_q[12:5];
  assign bus.buff_ctrl    = dp_q[4:1];
  assign bus.reg_write_en = dp_q[0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pc           = pc_q;

endmodule

// File: tb/tb_micro_seq.sv
// Self-checking bench for micro_seq: Fibonacci vector table, hand-written reset/load
// sequences, and randomized programs checked against a pass-by-pass issue-order model.
module tb_micro_seq;

  localparam logic [7:0]  NopOp  = 8'h5A;
  localparam logic [7:0]  AddOp  = 8'h01;
  localparam logic [40:0] NopW   = {28'h0, NopOp, 5'h0};

  typedef struct {
    logic        start;
    logic [40:0] exp;
    logic        busy;
    logic        done;
  } vec_t;

  logic clk;
  logic reset;
  micro_seq_if bus ();

  micro_seq #(.NOP_OP(NopOp)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_pass;
  logic [41:0] mem_m [16];
  logic [41:0] fw [4];
  vec_t        fib_vec [10];

  function automatic logic [41:0] mk(input logic [15:0] imm, input logic [3:0] ws,
                                     input logic [3:0] r1, input logic [3:0] r2,
                                     input logic [7:0] op, input logic [3:0] bf,
                                     input logic we, input logic last);
    return {imm, ws, r1, r2, op, bf, we, last};
  endfunction

  task automatic check(input string nm, input logic [40:0] ew, input logic eb,
                       input logic ed);
    logic [40:0] aw;
    aw = {bus.initial_r, bus.reg_write, bus.reg_read1, bus.reg_read2, bus.alu_op,
          bus.buff_ctrl, bus.reg_write_en};
    n_chk++;
    if (aw === ew && bus.busy === eb && bus.done === ed) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got word=%h busy=%b done=%b, expected word=%h busy=%b done=%b",
               nm, aw, bus.busy, bus.done, ew, eb, ed);
    end
  endtask

  task automatic check_pc(input string nm, input logic [3:0] ep);
    n_chk++;
    if (bus.pc === ep) n_pass++;
    else $display("FAIL %s: got pc=%h, expected pc=%h", nm, bus.pc, ep);
  endtask

  task automatic load(input logic [3:0] addr, input logic [41:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
    mem_m[addr] = data;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < 10; i++) begin
      bus.start = fib_vec[i].start;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check($sformatf("%s[%0d]", nm, i), fib_vec[i].exp, fib_vec[i].busy, fib_vec[i].done);
    end
  endtask

  // Model: walk the program pass by pass (first pass from 0, later from la) and list
  // the words in issue order; then compare edge by edge.
  task automatic run_check(input logic [3:0] la, input logic [7:0] lc, input int halt_at,
                           input int junk_at, input string nm);
    logic [40:0] exp_q [$];
    int a;
    int pass;
    int dedge;
    a    = 0;
    pass = 1;
    while (exp_q.size() < 200) begin
      exp_q.push_back(mem_m[a][41:1]);
      if (mem_m[a][0] || a == 15) begin
        if (lc != 0 && pass == int'(lc)) break;
        pass++;
        a = int'(la);
      end else begin
        a++;
      end
    end
    dedge = exp_q.size() + 1;
    if (halt_at >= 2 && halt_at < dedge) dedge = halt_at;
    bus.loop_addr  = la;
    bus.loop_count = lc;
    bus.start      = 1'b1;
    for (int e = 1; e <= dedge + 1; e++) begin
      bus.halt      = (e == halt_at);
      bus.load_en   = (e == junk_at && e >= 2 && e < dedge);
      bus.load_addr = la;
      bus.load_data = {10'h3FF, $urandom()};
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.halt    = 1'b0;
      bus.load_en = 1'b0;
      if (e < dedge) check($sformatf("%s edge%0d", nm, e), exp_q[e-1], 1'b1, 1'b0);
      else if (e == dedge) check($sformatf("%s done", nm), NopW, 1'b0, 1'b1);
      else check($sformatf("%s idle", nm), NopW, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int unsigned order [8];
    logic [63:0] rnd;
    int          h;
    int          j;
    logic [7:0]  lc;
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    bus.load_en    = 1'b0;
    bus.load_addr  = 4'd0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.loop_addr  = 4'd0;
    bus.loop_count = 8'd0;
    bus.halt       = 1'b0;
    reset          = 1'b0;

    fw[0] = mk(16'd1, 4'd0, 4'd0, 4'd0, 8'h00, 4'b0001, 1'b1, 1'b0);
    fw[1] = mk(16'd1, 4'd1, 4'd0, 4'd0, 8'h00, 4'b0001, 1'b1, 1'b0);
    fw[2] = mk(16'd0, 4'd1, 4'd0, 4'd1, AddOp, 4'b1110, 1'b1, 1'b0);
    fw[3] = mk(16'd0, 4'd0, 4'd1, 4'd0, AddOp, 4'b1110, 1'b1, 1'b1);
    order = '{0, 1, 2, 3, 2, 3, 2, 3};
    for (int i = 0; i < 8; i++) begin
      fib_vec[i] = '{start: (i == 0), exp: fw[order[i]][41:1], busy: 1'b1, done: 1'b0};
    end
    fib_vec[8] = '{start: 1'b0, exp: NopW, busy: 1'b0, done: 1'b1};
    fib_vec[9] = '{start: 1'b0, exp: NopW, busy: 1'b0, done: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", NopW, 1'b0, 1'b0);
    check_pc("reset_pc", 4'd0);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) load(4'(i), fw[i]);
    // start together with load_en: write wins, no run
    bus.start = 1'b1;
    load(4'd3, fw[3]);
    bus.start = 1'b0;
    check("start_with_load", NopW, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("start_with_load_idle", NopW, 1'b0, 1'b0);

    bus.loop_addr  = 4'd2;
    bus.loop_count = 8'd3;
    run_table("fib");

    // unbounded loop with a load attempt mid-run, halted after > 20 cycles
    run_check(4'd2, 8'd0, 26, 9, "unbounded");

    // re-run with start pulses during RUN; also proves the mid-run load was ignored
    bus.loop_addr  = 4'd2;
    bus.loop_count = 8'd3;
    fib_vec[3].start = 1'b1;
    fib_vec[5].start = 1'b1;
    run_table("fib_start_in_run");

    // mid-run reset during the second pass
    bus.start = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check($sformatf("pre_reset[%0d]", e), fw[order[e]][41:1], 1'b1, 1'b0);
    end
    #3;
    reset = 1'b0;
    #1;
    check("reset_async", NopW, 1'b0, 1'b0);
    check_pc("reset_async_pc", 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("no_done_after_reset[%0d]", i), NopW, 1'b0, 1'b0);
    end
    // cleared store: sixteen all-zero words (op 0, not NOP) then done on edge 17
    run_check(4'd0, 8'd1, 0, 0, "zero_mem");

    // implicit last at address 15
    for (int i = 0; i < 16; i++) begin
      load(4'(i), mk(16'(i * 3 + 1), 4'(i), 4'(15 - i), 4'(i + 1), 8'(i + 16), 4'(i), 1'b1,
                     1'b0));
    end
    run_check(4'd5, 8'd1, 0, 0, "implicit_last");

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) begin
        rnd = {$urandom(), $urandom()};
        rnd[0] = ($urandom_range(0, 3) == 0);
        load(4'(i), rnd[41:0]);
      end
      lc = 8'($urandom_range(0, 3));
      if (lc == 8'd0) h = int'($urandom_range(2, 40));
      else if ($urandom_range(0, 3) == 0) h = int'($urandom_range(2, 30));
      else h = 0;
      j = int'($urandom_range(0, 20));
      run_check(4'($urandom_range(0, 15)), lc, h, j, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/micro_seq.md
MICRO_SEQ -- requirements
Module: micro_seq

Interface
REQ-001 Parameter: NOP_OP, 8'h00, ALU opcode driven whenever no microword is issued.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: load_en  input  1  write load_data into microword memory at load_addr.
REQ-005 Port: load_addr  input  4  microword memory write address (16 entries).
REQ-006 Port: load_data  input  42  microword {imm[41:26], wsel[25:22], r1[21:18], r2[17:14], op[13:6], buf[5:2], we[1], last[0]}.
REQ-007 Port: start  input  1  begin program execution; sampled in IDLE only.
REQ-008 Port: loop_addr  input  4  re-entry address after each last word; captured on start.
REQ-009 Port: loop_count  input  8  number of passes through the loop body; 0 = unbounded; captured on start.
REQ-010 Port: halt  input  1  synchronous abort of a running program.
REQ-011 Port: initial_r  output  16  immediate to datapath input buffer.
REQ-012 Port: reg_write / reg_read1 / reg_read2  output  4 each  register file write and read selects.
REQ-013 Port: alu_op  output  8  ALU operation.
REQ-014 Port: buff_ctrl  output  4  datapath buffer enables.
REQ-015 Port: reg_write_en  output  1  register file write enable.
REQ-016 Port: busy  output  1  high while in RUN.
REQ-017 Port: done  output  1  one-cycle completion pulse.
REQ-018 Port: pc  output  4  address of the next microword to issue.

Function
REQ-019 All outputs SHALL be registered; "issue" SHALL mean loading the datapath outputs from the fields of word[pc] on a rising edge.
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 A "NOP word" SHALL be: imm=0, selects=0, op=NOP_OP, buf=0, we=0.
REQ-022 In IDLE, datapath outputs SHALL hold the NOP word; busy=0 and done=0.
REQ-023 Memory write: load_en high in IDLE SHALL write word[load_addr] on that edge; load_en in RUN or DONE SHALL be ignored.
REQ-024 IDLE with start=1 and load_en=0 SHALL, on that edge: enter RUN, issue word[0], set pc=1, capture loop_addr, set remaining=loop_count.
REQ-025 Start with load_en=1 in the same cycle SHALL be ignored; the write proceeds.
REQ-026 RUN, non-last word: issue word[pc] and set pc=pc+1.
REQ-027 A word SHALL be treated as last if its last bit is 1 or pc=15 (implicit last; no wrap to 0).
REQ-028 RUN, last word with loop_count=0: issue it, set pc=loop_addr, stay in RUN.
REQ-029 RUN, last word with remaining>1: issue it, decrement remaining, set pc=loop_addr.
REQ-030 RUN, last word with remaining=1: issue it, then enter DONE on the next edge.
REQ-031 The first pass SHALL run from address 0; later passes SHALL run from the captured loop_addr.
REQ-032 DONE SHALL last exactly one cycle (datapath outputs = NOP word, done=1, busy=0) and then return to IDLE.
REQ-033 halt=1 in RUN SHALL take priority over issue: next edge drives the NOP word and enters DONE.
REQ-034 halt and start SHALL be ignored in IDLE and DONE respectively.
REQ-035 Latency: start edge to first issued word = 0 edges; last issued word to done=1 = 1 edge.

Reset
REQ-036 reset low SHALL immediately force: state=IDLE, pc=0, remaining=0, datapath outputs = NOP word, busy=0, done=0.
REQ-037 reset low SHALL clear all 16 microwords to zero, including while in RUN (abort without a done pulse).
REQ-038 Release of reset SHALL be sampled synchronously; the first possible start is the first edge after release.

Verification
REQ-039 Fibonacci run. Load w0={imm1,wsel0,buf0001,we}, w1={imm1,wsel1,buf0001,we}, w2={ADD,w1,r0,r1,buf1110,we}, w3={ADD,w0,r1,r0,buf1110,we,last}; start with loop_addr=2, loop_count=3 -> issue order w0,w1,w2,w3,w2,w3,w2,w3; done=1 on the 9th edge; IDLE on the 10th.
REQ-040 Unbounded run. Same program with loop_count=0 -> w2,w3 alternate for more than 20 cycles; assert halt -> NOP word and done=1 on the next edge.
REQ-041 Mid-run reset. Assert reset during the second pass -> outputs go to the NOP word asynchronously; memory reads back zero; no done pulse.
REQ-042 Implicit last. Program with no last bits, loop_count=1 -> words 0..15 issued; done on edge 17; pc=0 never re-issued.
REQ-043 Load rules. Start and load_en in the same IDLE cycle -> no RUN, word written; load_en during RUN -> memory unchanged (checked by a re-run).
REQ-044 Start during RUN -> ignored; sequence and counts identical to REQ-039.
